// File: rtl/cpu6502_pkg.sv
// ---------------------------------------------------------------------------
// cpu6502_pkg
//   Shared definitions for the 6502 core slice: the flag_op_e encoding
//   driven by the instruction decoder and the bit positions of the
//   processor status register P (N V - B D I Z C).
// ---------------------------------------------------------------------------
package cpu6502_pkg;

    // Explicit flag set/clear operations requested by the decoder.
    typedef enum logic [2:0] {
        NONE = 3'd0,
        CLC  = 3'd1,
        SEC  = 3'd2,
        CLI  = 3'd3,
        SEI  = 3'd4,
        CLV  = 3'd5,
        CLD  = 3'd6,
        SED  = 3'd7
    } flag_op_e;

    // Bit positions inside P.
    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    // Assemble a P image from the six stored flags plus the value to show
    // in the B position (bit 5 always reads as 1).
    function automatic logic [7:0] pack_p(
        input logic n, input logic v, input logic b,
        input logic d, input logic i, input logic z, input logic c
    );
        logic [7:0] p;
        p      = 8'h00;
        p[P_N] = n;
        p[P_V] = v;
        p[P_U] = 1'b1;
        p[P_B] = b;
        p[P_D] = d;
        p[P_I] = i;
        p[P_Z] = z;
        p[P_C] = c;
        return p;
    endfunction

endpackage

// File: rtl/status_reg_if.sv
// ---------------------------------------------------------------------------
// status_reg_if
//   Bundles the status register's data/control signals.
//   master : decoder/ALU/sequencer side (drives strobes and operands,
//            receives P images and flag feedback)
//   slave  : status_reg itself
//   Signals:
//     alu_result/alu_carry/alu_overflow  ALU outputs to capture
//     update_nz/update_c/update_v        ALU capture strobes
//     flag_op                            SEx/CLx operation
//     bit_op, acc, mem_data              BIT instruction operands
//     load_p                             PLP/RTI load from mem_data
//     irq_entry, push_brk, instr_done    interrupt / sequencing controls
//     p_out, p_push                      P as register / as pushed to stack
//     carry_flag, decimal_flag           feedback to ALU
//     irq_mask                           instruction-delayed I flag
// ---------------------------------------------------------------------------
interface status_reg_if;
    import cpu6502_pkg::*;

    logic [7:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;
    logic       update_nz;
    logic       update_c;
    logic       update_v;
    flag_op_e   flag_op;
    logic       bit_op;
    logic [7:0] acc;
    logic [7:0] mem_data;
    logic       load_p;
    logic       irq_entry;
    logic       push_brk;
    logic       instr_done;
    logic [7:0] p_out;
    logic [7:0] p_push;
    logic       carry_flag;
    logic       decimal_flag;
    logic       irq_mask;

    modport master (
        output alu_result, alu_carry, alu_overflow,
        output update_nz, update_c, update_v, flag_op,
        output bit_op, acc, mem_data, load_p,
        output irq_entry, push_brk, instr_done,
        input  p_out, p_push, carry_flag, decimal_flag, irq_mask
    );

    modport slave (
        input  alu_result, alu_carry, alu_overflow,
        input  update_nz, update_c, update_v, flag_op,
        input  bit_op, acc, mem_data, load_p,
        input  irq_entry, push_brk, instr_done,
        output p_out, p_push, carry_flag, decimal_flag, irq_mask
    );

endinterface

// File: rtl/status_reg.sv
// ---------------------------------------------------------------------------
// status_reg
//   6502 processor status register P (N V - B D I Z C), downstream of the ALU.
//   Captures ALU N/Z/C/V under decoder strobes, services SEx/CLx, BIT,
//   PLP/RTI loads and interrupt entry, and supplies carry/decimal back to the
//   ALU, the stacked P image and an instruction-delayed IRQ mask.
//   Ports:
//     clk    system clock, all state on rising edge
//     rst_n  asynchronous active-low reset
//     bus    status_reg_if.slave (see interface for signal list)
//   Parameter:
//     RESET_P  value of p_out after reset
// ---------------------------------------------------------------------------
module status_reg
    import cpu6502_pkg::*;
#(
    parameter logic [7:0] RESET_P = 8'h34
) (
    input  logic        clk,
    input  logic        rst_n,
    status_reg_if.slave bus
);

    logic n_reg, v_reg, d_reg, i_reg, z_reg, c_reg;
    logic n_next, v_next, d_next, i_next, z_next, c_next;
    logic irq_mask_reg, irq_mask_next;

    always_comb begin
        n_next        = n_reg;
        v_next        = v_reg;
        d_next        = d_reg;
        i_next        = i_reg;
        z_next        = z_reg;
        c_next        = c_reg;
        irq_mask_next = irq_mask_reg;

        // N / Z: pulled byte, then BIT, then ALU result.
        if (bus.load_p) begin
            n_next = bus.mem_data[P_N];
            z_next = bus.mem_data[P_Z];
        end else if (bus.bit_op) begin
            n_next = bus.mem_data[7];
            z_next = ((bus.acc & bus.mem_data) == 8'h00);
        end else if (bus.update_nz) begin
            n_next = bus.alu_result[7];
            z_next = (bus.alu_result == 8'h00);
        end

        // V: CLV outranks an ALU overflow captured on the same edge.
        if (bus.load_p)
            v_next = bus.mem_data[P_V];
        else if (bus.bit_op)
            v_next = bus.mem_data[6];
        else if (bus.flag_op == CLV)
            v_next = 1'b0;
        else if (bus.update_v)
            v_next = bus.alu_overflow;

        // C
        if (bus.load_p)
            c_next = bus.mem_data[P_C];
        else if (bus.flag_op == CLC)
            c_next = 1'b0;
        else if (bus.flag_op == SEC)
            c_next = 1'b1;
        else if (bus.update_c)
            c_next = bus.alu_carry;

        // D
        if (bus.load_p)
            d_next = bus.mem_data[P_D];
        else if (bus.flag_op == CLD)
            d_next = 1'b0;
        else if (bus.flag_op == SED)
            d_next = 1'b1;

        // I: interrupt entry always masks.
        if (bus.irq_entry)
            i_next = 1'b1;
        else if (bus.load_p)
            i_next = bus.mem_data[P_I];
        else if (bus.flag_op == CLI)
            i_next = 1'b0;
        else if (bus.flag_op == SEI)
            i_next = 1'b1;

        // The mask follows the OLD I at instruction boundaries, so a
        // CLI/SEI/PLP only takes effect for interrupt polling one
        // instruction later. Interrupt entry masks immediately.
        if (bus.irq_entry)
            irq_mask_next = 1'b1;
        else if (bus.instr_done)
            irq_mask_next = i_reg;

        // Stacked image: B reflects the push source, not stored state.
        bus.p_push = pack_p(n_reg, v_reg, bus.push_brk, d_reg, i_reg, z_reg, c_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg        <= RESET_P[P_N];
            v_reg        <= RESET_P[P_V];
            d_reg        <= RESET_P[P_D];
            i_reg        <= RESET_P[P_I];
            z_reg        <= RESET_P[P_Z];
            c_reg        <= RESET_P[P_C];
            irq_mask_reg <= 1'b1;
        end else begin
            n_reg        <= n_next;
            v_reg        <= v_next;
            d_reg        <= d_next;
            i_reg        <= i_next;
            z_reg        <= z_next;
            c_reg        <= c_next;
            irq_mask_reg <= irq_mask_next;
        end
    end

    // Stored flags drive the outputs directly; bits 5/4 of p_out are
    // constant 1 because B only exists in the pushed image.
    assign bus.p_out        = pack_p(n_reg, v_reg, 1'b1, d_reg, i_reg, z_reg, c_reg);
    assign bus.carry_flag   = c_reg;
    assign bus.decimal_flag = d_reg;
    assign bus.irq_mask     = irq_mask_reg;

    // Decoder contract checks (ignored by synthesis).
    bit_nz_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n) !(bus.bit_op && bus.update_nz)
    ) else $error("status_reg: bit_op and update_nz asserted together");

    bit_load_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n) !(bus.bit_op && bus.load_p)
    ) else $error("status_reg: bit_op and load_p asserted together");

endmodule

// File: tb/tb_status_reg.sv
// ---------------------------------------------------------------------------
// tb_status_reg
//   Directed vectors with hand-computed P images for status_reg.
// ---------------------------------------------------------------------------
module tb_status_reg;
    import cpu6502_pkg::*;

    logic clk;
    logic rst_n;
    int   n_compared;
    int   n_mismatched;

    status_reg_if bus ();

    status_reg #(.RESET_P(8'h34)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end else begin
            $display("ok   %s: %02h", tag, got);
        end
    endtask

    task automatic clear_strobes();
        bus.update_nz  = 1'b0;
        bus.update_c   = 1'b0;
        bus.update_v   = 1'b0;
        bus.flag_op    = NONE;
        bus.bit_op     = 1'b0;
        bus.load_p     = 1'b0;
        bus.irq_entry  = 1'b0;
        bus.instr_done = 1'b0;
    endtask

    // Apply the currently driven strobes for exactly one rising edge,
    // then settle 1 time unit past it and drop the strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n            = 1'b0;
        bus.alu_result   = 8'h00;
        bus.alu_carry    = 1'b0;
        bus.alu_overflow = 1'b0;
        bus.acc          = 8'h00;
        bus.mem_data     = 8'h00;
        bus.push_brk     = 1'b0;
        clear_strobes();

        #12 rst_n = 1'b1;
        #1;
        check_eq("reset_p", bus.p_out, 8'h34);
        check_eq("reset_mask", {7'd0, bus.irq_mask}, 8'h01);

        // 1. Async reset mid-clock, with a pending update held on the strobes.
        bus.flag_op = SEC; bus.flag_op = SEC;
        tick();
        check_eq("sec_before_rst", bus.p_out, 8'h35);
        bus.flag_op = SED;
        bus.update_nz = 1'b1; bus.alu_result = 8'h80;
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_p", bus.p_out, 8'h34);
        check_eq("async_rst_mask", {7'd0, bus.irq_mask}, 8'h01);
        check_eq("async_rst_carry", {7'd0, bus.carry_flag}, 8'h00);
        @(posedge clk); #1;
        check_eq("rst_held_p", bus.p_out, 8'h34);
        #2 rst_n = 1'b1;
        clear_strobes();

        // 2. ALU capture.
        bus.alu_result = 8'h80; bus.alu_carry = 1'b1; bus.alu_overflow = 1'b1;
        bus.update_nz = 1'b1; bus.update_c = 1'b1; bus.update_v = 1'b1;
        tick();
        check_eq("alu_capture", bus.p_out, 8'hF5);
        check_eq("push_img_f5", bus.p_push, 8'hE5);
        bus.alu_result = 8'h00; bus.update_nz = 1'b1;
        tick();
        check_eq("alu_zero", bus.p_out, 8'h77);

        // 3. BIT: N/V from operand, Z from acc & operand; C D I untouched.
        bus.acc = 8'h0F; bus.mem_data = 8'hC0; bus.bit_op = 1'b1;
        tick();
        check_eq("bit_op", bus.p_out, 8'hF7);
        check_eq("bit_carry", {7'd0, bus.carry_flag}, 8'h01);

        // 4. Priority: load_p beats SEC / update_c; irq_entry beats load_p.
        bus.mem_data = 8'h00; bus.load_p = 1'b1; bus.flag_op = SEC;
        bus.update_c = 1'b1; bus.alu_carry = 1'b1;
        tick();
        check_eq("loadp_over_sec", bus.p_out, 8'h30);
        bus.mem_data = 8'h00; bus.load_p = 1'b1; bus.irq_entry = 1'b1;
        tick();
        check_eq("irq_over_loadp", bus.p_out, 8'h34);
        bus.mem_data = 8'hFF; bus.load_p = 1'b1;
        tick();
        check_eq("loadp_ff", bus.p_out, 8'hFF);
        bus.mem_data = 8'h30; bus.load_p = 1'b1;
        tick();
        check_eq("loadp_ignores_54", bus.p_out, 8'h30);

        // CLV beats update_v on the same edge; then update_v alone sets V.
        bus.flag_op = CLV; bus.update_v = 1'b1; bus.alu_overflow = 1'b1;
        tick();
        check_eq("clv_over_upd_v", bus.p_out, 8'h30);
        bus.update_v = 1'b1; bus.alu_overflow = 1'b1;
        tick();
        check_eq("upd_v", bus.p_out, 8'h70);
        bus.flag_op = SED;
        tick();
        check_eq("sed", bus.p_out, 8'h78);
        check_eq("decimal_flag", {7'd0, bus.decimal_flag}, 8'h01);
        bus.flag_op = CLD;
        tick();
        check_eq("cld", bus.p_out, 8'h70);
        tick();
        check_eq("hold", bus.p_out, 8'h70);

        // 5. IRQ mask delay.
        bus.flag_op = SEI;
        tick();
        check_eq("sei", bus.p_out, 8'h74);
        bus.flag_op = CLI; bus.instr_done = 1'b1;
        tick();
        check_eq("cli_p", bus.p_out, 8'h70);
        check_eq("cli_mask_old", {7'd0, bus.irq_mask}, 8'h01);
        bus.instr_done = 1'b1;
        tick();
        check_eq("mask_follows", {7'd0, bus.irq_mask}, 8'h00);
        bus.flag_op = SEI;
        tick();
        check_eq("sei_no_done_mask", {7'd0, bus.irq_mask}, 8'h00);
        bus.instr_done = 1'b1;
        tick();
        check_eq("sei_done_mask", {7'd0, bus.irq_mask}, 8'h01);
        bus.flag_op = CLI; bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b1;
        tick();
        check_eq("mask_clear_again", {7'd0, bus.irq_mask}, 8'h00);
        bus.irq_entry = 1'b1;
        tick();
        check_eq("irq_entry_mask", {7'd0, bus.irq_mask}, 8'h01);
        check_eq("irq_entry_p", bus.p_out, 8'h74);

        // 6. Push image from reset state.
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        bus.push_brk = 1'b0;
        #1;
        check_eq("push_irq", bus.p_push, 8'h24);
        bus.push_brk = 1'b1;
        #1;
        check_eq("push_brk", bus.p_push, 8'h34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
